// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32-subset control unit.
// Opcodes, ALU operation codes, FSM state encodings and the strobe bundle.
package multicycle_control_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OP_LD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_SD  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_LDWB    = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  // Datapath strobes and mux selects driven by the sequencer.
  typedef struct packed {
    logic pcwrite;
    logic pcsrc;
    logic iord;
    logic irwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic regwrite;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Funct -> ALU Operation decode, shared with the single-cycle control.
// funct_ok_c flags Funct values outside the supported add/sub/and/or set.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUOP_W-1:0] operation_c,
  output logic               funct_ok_c
);

  always_comb begin
    operation_c = ALU_ADD;
    funct_ok_c  = 1'b1;
    case (funct)
      4'b0000: operation_c = ALU_ADD;
      4'b1000: operation_c = ALU_SUB;
      4'b0111: operation_c = ALU_AND;
      4'b0110: operation_c = ALU_OR;
      default: funct_ok_c  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for ld/sd/beq/R-type: steps FETCH..WB with a mem_ready stall,
// drives PC/IR enables, memory strobes, register write and the ALU Operation.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] Operation,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   retired
);

  state_t             state_q, state_d;
  ctrl_t              ctrl_c;
  logic [ALUOP_W-1:0] op_c;
  logic [ALUOP_W-1:0] rop_c, rop_q;
  logic               rop_ok_c;
  logic               retire_c;

  multicycle_control_alu_decoder u_alu_dec (
    .funct       (Funct),
    .operation_c (rop_c),
    .funct_ok_c  (rop_ok_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type operation is captured in EXEC_R so RWB does not depend on a live Funct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rop_q   <= ALU_ADD;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state_q == S_EXEC_R) rop_q <= rop_c;
      if (state_d == S_ILLEGAL) illegal <= 1'b1;
      if (retire_c) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_c   = '0;
    op_c     = ALU_ADD;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.memread = 1'b1;
        if (mem_ready) begin
          ctrl_c.irwrite = 1'b1;
          ctrl_c.pcwrite = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_LD, OP_SD: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_R:         state_d = S_EXEC_R;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADDR: begin
        ctrl_c.alusrc = 1'b1;
        state_d       = (Opcode == OP_SD) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl_c.memread = 1'b1;
        ctrl_c.iord    = 1'b1;
        ctrl_c.alusrc  = 1'b1;
        if (mem_ready) state_d = S_LDWB;
      end
      S_LDWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memtoreg = 1'b1;
        retire_c        = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl_c.memwrite = 1'b1;
        ctrl_c.iord     = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        op_c    = rop_c;
        state_d = rop_ok_c ? S_RWB : S_ILLEGAL;
      end
      S_RWB: begin
        ctrl_c.regwrite = 1'b1;
        op_c            = rop_q;
        retire_c        = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        op_c           = ALU_SUB;
        ctrl_c.pcsrc   = 1'b1;
        ctrl_c.pcwrite = Zero;
        retire_c       = 1'b1;
        state_d        = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so FETCH never reads during reset.
  assign PCWrite   = ctrl_c.pcwrite  & ~reset;
  assign PCSrc     = ctrl_c.pcsrc    & ~reset;
  assign IorD      = ctrl_c.iord     & ~reset;
  assign IRWrite   = ctrl_c.irwrite  & ~reset;
  assign MemRead   = ctrl_c.memread  & ~reset;
  assign MemWrite  = ctrl_c.memwrite & ~reset;
  assign MemtoReg  = ctrl_c.memtoreg & ~reset;
  assign ALUSrc    = ctrl_c.alusrc   & ~reset;
  assign RegWrite  = ctrl_c.regwrite & ~reset;
  assign Operation = op_c;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction-level model expands each
// instruction into its expected per-cycle phases; a negedge process compares them.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam logic [6:0] LD_OPC  = 7'b0000011;
  localparam logic [6:0] SD_OPC  = 7'b0100011;
  localparam logic [6:0] BEQ_OPC = 7'b1100011;
  localparam logic [6:0] R_OPC   = 7'b0110011;
  localparam logic [6:0] BAD_OPC = 7'b0010011;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;

  typedef enum int {P_FETCH, P_DECODE, P_MEMADDR, P_MEMRD, P_LDWB, P_MEMWR,
                    P_EXEC, P_RWB, P_BRANCH, P_ILL} ph_t;

  typedef struct packed {
    logic [6:0]  opc;
    logic [3:0]  fn;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [8:0]  strb;
    logic [3:0]  op;
    logic        chk_op;
    logic        ill;
    logic [31:0] ret;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic [3:0] Funct = 4'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, illegal;
  logic [3:0]  Operation, state_o;
  logic [15:0] retired;
  logic PCWrite_b, PCSrc_b, IorD_b, IRWrite_b, MemRead_b, MemWrite_b, MemtoReg_b, ALUSrc_b;
  logic RegWrite_b, illegal_b;
  logic [3:0] Operation_b, state_o_b;
  logic [1:0] retired_b;

  int   nvec = 0;
  int   nerr = 0;
  rec_t expq[$];
  int   model_ret = 0;
  logic model_ill = 1'b0;

  int         lat_cnt = 0;
  int         lat_last = 0;
  logic [15:0] prev_ret = 16'd0;
  logic [3:0] rwb_op = 4'hf;
  logic       br_pcw = 1'bx;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Operation(Operation), .illegal(illegal),
    .state_o(state_o), .retired(retired)
  );

  multicycle_control #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite_b), .PCSrc(PCSrc_b), .IorD(IorD_b),
    .IRWrite(IRWrite_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b), .MemtoReg(MemtoReg_b),
    .ALUSrc(ALUSrc_b), .RegWrite(RegWrite_b), .Operation(Operation_b), .illegal(illegal_b),
    .state_o(state_o_b), .retired(retired_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] strb_a();
    return {PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite};
  endfunction

  function automatic logic [8:0] strb_b();
    return {PCWrite_b, PCSrc_b, IorD_b, IRWrite_b, MemRead_b, MemWrite_b, MemtoReg_b,
            ALUSrc_b, RegWrite_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {ok, op} for an R-type Funct
  function automatic logic [4:0] exp_alu(input logic [3:0] fn);
    case (fn)
      4'b0000: return {1'b1, A_ADD};
      4'b1000: return {1'b1, A_SUB};
      4'b0111: return {1'b1, A_AND};
      4'b0110: return {1'b1, A_OR};
      default: return {1'b0, A_ADD};
    endcase
  endfunction

  // Expected outputs for one cycle spent in phase p with the given inputs.
  function automatic rec_t mk(input ph_t p, input logic [6:0] opc, input logic [3:0] fn,
                              input logic z, input logic mr, input logic [3:0] aop,
                              input logic aok);
    rec_t r;
    logic pcw, pcsrc, iord, irw, mrd, mwr, m2r, alusrc, rw;
    {pcw, pcsrc, iord, irw, mrd, mwr, m2r, alusrc, rw} = 9'd0;
    r = '0;
    r.opc = opc; r.fn = fn; r.z = z; r.mr = mr;
    r.ret = 32'(model_ret);
    r.ill = model_ill;
    r.op  = A_ADD;
    case (p)
      P_FETCH:   begin r.st = S_FETCH; mrd = 1'b1; irw = mr; pcw = mr; end
      P_DECODE:  begin r.st = S_DECODE; r.chk_op = 1'b1; end
      P_MEMADDR: begin r.st = S_MEMADDR; alusrc = 1'b1; r.chk_op = 1'b1; end
      P_MEMRD:   begin r.st = S_MEMRD; mrd = 1'b1; iord = 1'b1; alusrc = 1'b1; r.chk_op = 1'b1; end
      P_LDWB:    begin r.st = S_LDWB; rw = 1'b1; m2r = 1'b1; end
      P_MEMWR:   begin r.st = S_MEMWR; mwr = 1'b1; iord = 1'b1; alusrc = 1'b1; r.chk_op = 1'b1; end
      P_EXEC:    begin r.st = S_EXEC_R; r.op = aop; r.chk_op = aok; end
      P_RWB:     begin r.st = S_RWB; rw = 1'b1; r.op = aop; r.chk_op = 1'b1; end
      P_BRANCH:  begin r.st = S_BRANCH; r.op = A_SUB; r.chk_op = 1'b1; pcsrc = 1'b1; pcw = z; end
      default:   r.st = S_ILLEGAL;
    endcase
    r.strb = {pcw, pcsrc, iord, irw, mrd, mwr, m2r, alusrc, rw};
    return r;
  endfunction

  task automatic step(input rec_t r);
    @(posedge clk); #1;
    reset = 1'b0;
    Opcode = r.opc; Funct = r.fn; Zero = r.z; mem_ready = r.mr;
    expq.push_back(r);
  endtask

  // One whole instruction: fw FETCH stalls, mw memory stalls.
  task automatic instr(input logic [6:0] opc, input logic [3:0] fn, input logic z,
                       input int fw, input int mw);
    logic [4:0] a;
    ph_t mp;
    a = exp_alu(fn);
    mp = (opc == LD_OPC) ? P_MEMRD : P_MEMWR;
    for (int i = 0; i < fw; i++) step(mk(P_FETCH, opc, fn, z, 1'b0, A_ADD, 1'b0));
    step(mk(P_FETCH, opc, fn, z, 1'b1, A_ADD, 1'b0));
    step(mk(P_DECODE, opc, fn, z, 1'b1, A_ADD, 1'b0));
    if (opc == LD_OPC || opc == SD_OPC) begin
      step(mk(P_MEMADDR, opc, fn, z, 1'b1, A_ADD, 1'b0));
      for (int i = 0; i < mw; i++) step(mk(mp, opc, fn, z, 1'b0, A_ADD, 1'b0));
      step(mk(mp, opc, fn, z, 1'b1, A_ADD, 1'b0));
      if (opc == LD_OPC) step(mk(P_LDWB, opc, 4'b1111, z, 1'b1, A_ADD, 1'b0));
      model_ret++;
    end else if (opc == BEQ_OPC) begin
      step(mk(P_BRANCH, opc, fn, z, 1'b1, A_ADD, 1'b0));
      model_ret++;
    end else if (opc == R_OPC) begin
      step(mk(P_EXEC, opc, fn, z, 1'b1, a[3:0], a[4]));
      if (a[4]) begin
        step(mk(P_RWB, opc, 4'b1111, z, 1'b1, a[3:0], 1'b1));
        model_ret++;
      end else begin
        model_ill = 1'b1;
      end
    end else begin
      model_ill = 1'b1;
    end
  endtask

  // Park in FETCH for one cycle, then sit just after its negedge for literal checks.
  task automatic idle_chk();
    step(mk(P_FETCH, R_OPC, 4'b0000, 1'b0, 1'b0, A_ADD, 1'b0));
    @(negedge clk); #1;
  endtask

  task automatic ill_idle(input int n);
    for (int i = 0; i < n; i++) step(mk(P_ILL, R_OPC, 4'b0000, 1'b0, 1'b1, A_ADD, 1'b0));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1; Opcode = R_OPC; Funct = 4'b0000;
    model_ret = 0; model_ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_strobes", 32'(strb_a()), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("state", 32'(state_o), 32'(e.st));
      chk("strobes", 32'(strb_a()), 32'(e.strb));
      if (e.chk_op) chk("operation", 32'(Operation), 32'(e.op));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("retired", 32'(retired), 32'(e.ret[15:0]));
      chk("state_b", 32'(state_o_b), 32'(e.st));
      chk("strobes_b", 32'(strb_b()), 32'(e.strb));
      chk("retired_b", 32'(retired_b), 32'(e.ret[1:0]));
    end
  end

  // Observed latency (IRWrite cycle through retiring cycle), RWB op and branch PCWrite.
  always @(negedge clk) begin
    if (reset) begin
      lat_cnt  = 0;
      prev_ret = 16'd0;
    end else begin
      if (retired != prev_ret) lat_last = lat_cnt;
      prev_ret = retired;
      if (IRWrite) lat_cnt = 1;
      else lat_cnt++;
      if (RegWrite && !MemtoReg) rwb_op = Operation;
      if (PCSrc) br_pcw = PCWrite;
    end
  end

  initial begin
    logic [3:0] fns [4];
    logic [3:0] ops [4];
    logic [1:0] r2  [5];
    fns = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    r2  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    do_reset(2);

    instr(LD_OPC, 4'b0000, 1'b0, 0, 2);
    idle_chk();
    chk("ld_retired", 32'(retired), 32'd1);
    chk("ld_latency", 32'(lat_last), 32'd7);

    for (int i = 0; i < 4; i++) begin
      instr(R_OPC, fns[i], 1'b0, (i == 0) ? 1 : 0, 0);
      idle_chk();
      chk("r_operation", 32'(rwb_op), 32'(ops[i]));
      chk("r_latency", 32'(lat_last), 32'd4);
    end

    instr(BEQ_OPC, 4'b0000, 1'b1, 0, 0);
    idle_chk();
    chk("beq_taken_pcwrite", 32'(br_pcw), 32'd1);
    chk("beq_latency", 32'(lat_last), 32'd3);
    instr(BEQ_OPC, 4'b0000, 1'b0, 0, 0);
    idle_chk();
    chk("beq_not_taken_pcwrite", 32'(br_pcw), 32'd0);
    chk("retired_after_beq", 32'(retired), 32'd7);

    instr(BAD_OPC, 4'b0000, 1'b0, 0, 0);
    ill_idle(3);
    @(negedge clk); #1;
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_state", 32'(state_o), 32'd9);
    chk("ill_strobes", 32'(strb_a()), 32'd0);
    chk("ill_retired_frozen", 32'(retired), 32'd7);

    do_reset(1);
    instr(R_OPC, 4'b0001, 1'b0, 0, 0);
    ill_idle(2);
    @(negedge clk); #1;
    chk("ill_funct_flag", 32'(illegal), 32'd1);
    chk("ill_funct_retired", 32'(retired), 32'd0);

    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      instr(SD_OPC, 4'b0000, 1'b0, 0, i % 2);
      idle_chk();
      chk("sd_retired_wrap", 32'(retired_b), 32'(r2[i]));
      chk("sd_latency", 32'(lat_last), 32'(4 + (i % 2)));
    end

    step(mk(P_FETCH, SD_OPC, 4'b0000, 1'b0, 1'b1, A_ADD, 1'b0));
    step(mk(P_DECODE, SD_OPC, 4'b0000, 1'b0, 1'b1, A_ADD, 1'b0));
    step(mk(P_MEMADDR, SD_OPC, 4'b0000, 1'b0, 1'b1, A_ADD, 1'b0));
    step(mk(P_MEMWR, SD_OPC, 4'b0000, 1'b0, 1'b0, A_ADD, 1'b0));
    step(mk(P_MEMWR, SD_OPC, 4'b0000, 1'b0, 1'b0, A_ADD, 1'b0));
    @(negedge clk); #1;
    chk("memwrite_before_reset", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("memwrite_at_reset", 32'(MemWrite), 32'd0);
    chk("memread_at_reset", 32'(MemRead), 32'd0);
    chk("state_at_reset", 32'(state_o), 32'd0);
    chk("retired_at_reset", 32'(retired), 32'd0);

    do_reset(1);
    instr(BEQ_OPC, 4'b0000, 1'b1, 0, 0);
    idle_chk();
    chk("retired_after_recovery", 32'(retired), 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
